dm_access_ctrl: RTL

Sequencing and arbitration controller in front of the word-wide data memory. It accepts byte/halfword/word load and store requests from two requesters: port 0, CPU load/store unit; port 1, debug/loader port. It arbitrates round-robin between them and drives the single memory port. Sub-word stores become a read-modify-write sequence, and loads are returned sign- or zero-extended.

---
 rtl/dm_access_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dm_access_ctrl.sv
// Round-robin access controller for the word-wide data memory: two requesters,
// byte/half/word loads with extension, sub-word stores via read-modify-write.
module dm_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [1:0]        size0,
  input  logic [1:0]        size1,
  input  logic              sext0,
  input  logic              sext1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_MERGE,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  state_e      state;
  logic        last_grant;
  logic        port_q;
  logic        we_q;
  size_e       size_q;
  logic        sext_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        mem_we_q;

  logic        grant_valid;
  logic        grant_port;
  logic        sel_we;
  size_e       sel_size;
  logic        sel_sext;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_illegal;

  function automatic logic req_illegal(input size_e size, input logic [31:0] addr);
    logic bad;
    bad = (addr[31:ADDR_W+2] != '0);
    case (size)
      SZ_HALF: bad = bad | addr[0];
      SZ_WORD: bad = bad | (addr[1:0] != 2'b00);
      SZ_BAD:  bad = 1'b1;
      default: ;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e size,
                                              input logic sext, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: return {{24{sext & b[7]}}, b};
      SZ_HALF: return {{16{sext & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                              input size_e size, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    case (size)
      SZ_BYTE: m[{lane, 3'b000} +: 8]     = data[7:0];
      SZ_HALF: m[{lane[1], 4'b0000} +: 16] = data[15:0];
      default: m = data;
    endcase
    return m;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    grant_valid = req0 | req1;
    grant_port  = 1'b0;
    if (req0 && req1) grant_port = ~last_grant;
    else if (!req0)   grant_port = 1'b1;
    sel_we      = grant_port ? we1 : we0;
    sel_size    = size_e'(grant_port ? size1 : size0);
    sel_sext    = grant_port ? sext1 : sext0;
    sel_addr    = grant_port ? addr1 : addr0;
    sel_wdata   = grant_port ? wdata1 : wdata0;
    sel_illegal = req_illegal(sel_size, sel_addr);
  end

  // Gating with reset keeps an in-flight write from committing on the aborting edge.
  assign mem_we = mem_we_q & ~reset;

  // The merged word is formed from mem_rdata on the ACCESS edge, so the
  // mem_wdata register doubles as the merge buffer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      sext_q     <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_we_q   <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            port_q     <= grant_port;
            we_q       <= sel_we;
            size_q     <= sel_size;
            sext_q     <= sel_sext;
            lane_q     <= sel_addr[1:0];
            wdata_q    <= sel_wdata;
            last_grant <= grant_port;
            busy       <= 1'b1;
            if (sel_illegal) begin
              err          <= 1'b1;
              {ack1, ack0} <= grant_port ? 2'b10 : 2'b01;
              state        <= S_RESP;
            end else begin
              mem_addr <= sel_addr[ADDR_W+1:2];
              if (sel_we && sel_size == SZ_WORD) begin
                mem_we_q  <= 1'b1;
                mem_wdata <= sel_wdata;
              end
              state <= S_ACCESS;
            end
          end
        end

        S_ACCESS: begin
          mem_we_q <= 1'b0;
          if (!we_q) begin
            rdata        <= load_extend(mem_rdata, size_q, sext_q, lane_q);
            {ack1, ack0} <= port_q ? 2'b10 : 2'b01;
            state        <= S_RESP;
          end else if (size_q == SZ_WORD) begin
            {ack1, ack0} <= port_q ? 2'b10 : 2'b01;
            state        <= S_RESP;
          end else begin
            mem_we_q  <= 1'b1;
            mem_wdata <= store_merge(mem_rdata, wdata_q, size_q, lane_q);
            state     <= S_MERGE;
          end
        end

        S_MERGE: begin
          mem_we_q     <= 1'b0;
          {ack1, ack0} <= port_q ? 2'b10 : 2'b01;
          state        <= S_RESP;
        end

        S_RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
